sram_ctrl: RTL and testbench

Synchronous front-end for the pulse-driven 128×32 SRAM macro. Accepts single load/store requests from the core's memory stage over a valid/ready handshake, converts byte addresses and RISC-V access sizes into word select and byte-lane enables, and sequences `read_pulse`/`write_pulse` with setup and hold margins. Returns aligned, sign- or zero-extended load data on a one-cycle response strobe.

---
 rtl/sram_ctrl_pkg.sv | 31 +++
 rtl/sram_lane_align.sv | 49 ++++
 rtl/sram_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the pulse-driven 128x32 SRAM front-end.
package sram_ctrl_pkg;

    localparam int SRAM_WORDS  = 128;
    localparam int SRAM_ADDR_W = 7;

    // RISC-V funct3 access-size encodings
    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_RESP
    } state_e;

    // Unsigned loads have no store counterpart.
    function automatic logic size_illegal(input logic [2:0] size, input logic we);
        case (size)
            SIZE_B, SIZE_H, SIZE_W: return 1'b0;
            SIZE_BU, SIZE_HU:       return we;
            default:                return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational lane logic: byte enables, store shift, load shift/extend and
// misalignment detection. Misaligned low bits are forced to natural alignment.
module sram_lane_align
    import sram_ctrl_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [1:0]  lane_eff,
    output logic [3:0]  byte_sel,
    output logic [31:0] datain,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] shifted;

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        lane_eff = lane;
        misalign = 1'b0;
        byte_sel = 4'b0001 << lane;
        case (size[1:0])
            2'b01: begin
                misalign = lane[0];
                lane_eff = {lane[1], 1'b0};
                byte_sel = 4'b0011 << lane_eff;
            end
            2'b10: begin
                misalign = |lane;
                lane_eff = 2'b00;
                byte_sel = 4'b1111;
            end
            default: ;
        endcase

        datain  = wdata << {lane_eff, 3'b000};
        shifted = rdata_raw >> {lane_eff, 3'b000};

        // size[2] marks the unsigned loads
        case (size[1:0])
            2'b00:   rdata = {{24{~size[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   rdata = {{16{~size[2] & shifted[15]}}, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// Request FSM and pulse sequencer for the 128x32 SRAM macro.
// Define SRAM_CTRL_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES = 2
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [8:0]             req_addr,
    input  logic [2:0]             req_size,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [SRAM_ADDR_W-1:0] sram_addr_sel,
    output logic [3:0]             sram_byte_sel,
    output logic                   sram_read_pulse,
    output logic                   sram_write_pulse,
    output logic [31:0]            sram_datain,
    input  logic [31:0]            sram_dataout
);

`ifdef SRAM_CTRL_MISALIGN_TRAP_EN
    localparam logic TRAP_MISALIGN = 1'b1;
`else
    localparam logic TRAP_MISALIGN = 1'b0;
`endif

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             lane_q, lane_d;
    logic                   err_q, err_d;
    logic [SRAM_ADDR_W-1:0] addr_sel_q, addr_sel_d;
    logic [3:0]             byte_sel_q, byte_sel_d;
    logic [31:0]            datain_q, datain_d;
    logic [31:0]            rdata_q, rdata_d;

    logic        idle;
    logic [1:0]  lane_in, lane_eff;
    logic [2:0]  size_in;
    logic [3:0]  byte_sel;
    logic [31:0] datain, rdata_ext;
    logic        misalign, reject;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner sees the incoming request; afterwards the captured one.
    assign lane_in = idle ? req_addr[1:0] : lane_q;
    assign size_in = idle ? req_size : size_q;

    sram_lane_align u_align (
        .lane      (lane_in),
        .size      (size_in),
        .wdata     (req_wdata),
        .rdata_raw (sram_dataout),
        .lane_eff  (lane_eff),
        .byte_sel  (byte_sel),
        .datain    (datain),
        .rdata     (rdata_ext),
        .misalign  (misalign)
    );

    assign reject = size_illegal(req_size, req_we) | (TRAP_MISALIGN & misalign);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        lane_d     = lane_q;
        err_d      = err_q;
        addr_sel_d = addr_sel_q;
        byte_sel_d = byte_sel_q;
        datain_d   = datain_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    lane_d  = lane_eff;
                    err_d   = reject;
                    rdata_d = '0;
                    if (reject) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d    = ST_SETUP;
                        addr_sel_d = req_addr[8:2];
                        byte_sel_d = byte_sel;
                        datain_d   = datain;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = PULSE_LAST;
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    if (!we_q) rdata_d = rdata_ext;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: state_d = ST_RESP;
            ST_RESP: begin
                state_d    = ST_IDLE;
                err_d      = 1'b0;
                addr_sel_d = '0;
                byte_sel_d = '0;
                datain_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            lane_q     <= '0;
            err_q      <= 1'b0;
            addr_sel_q <= '0;
            byte_sel_q <= '0;
            datain_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            lane_q     <= lane_d;
            err_q      <= err_d;
            addr_sel_q <= addr_sel_d;
            byte_sel_q <= byte_sel_d;
            datain_q   <= datain_d;
            rdata_q    <= rdata_d;
        end
    end

    // Pulses decode straight from the state flop so an async reset drops them at once.
    assign sram_read_pulse  = (state_q == ST_PULSE) && !we_q;
    assign sram_write_pulse = (state_q == ST_PULSE) && we_q;

    assign req_ready     = idle && rst_n;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_err       = err_q;
    assign rsp_rdata     = rsp_valid ? rdata_q : '0;
    assign sram_addr_sel = addr_sel_q;
    assign sram_byte_sel = byte_sel_q;
    assign sram_datain   = datain_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed cases then random requests checked
// against a byte-addressed reference memory; a separate pin-level SRAM model serves the DUT.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int PULSE_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [8:0]  req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [6:0]  sram_addr_sel;
    logic [3:0]  sram_byte_sel;
    logic        sram_read_pulse, sram_write_pulse;
    logic [31:0] sram_datain, sram_dataout;

    always #5 clk = ~clk;

    sram_ctrl #(.PULSE_CYCLES(PULSE_CYCLES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .sram_addr_sel    (sram_addr_sel),
        .sram_byte_sel    (sram_byte_sel),
        .sram_read_pulse  (sram_read_pulse),
        .sram_write_pulse (sram_write_pulse),
        .sram_datain      (sram_datain),
        .sram_dataout     (sram_dataout)
    );

    // Pin-level SRAM: lane-masked writes while the write pulse is high.
    logic [31:0] sram_mem [SRAM_WORDS];
    always @(posedge clk) begin
        if (sram_write_pulse)
            for (int i = 0; i < 4; i++)
                if (sram_byte_sel[i]) sram_mem[sram_addr_sel][8*i +: 8] <= sram_datain[8*i +: 8];
    end
    assign sram_dataout = sram_read_pulse ? sram_mem[sram_addr_sel] : 32'h0;

    int rd_cyc = 0, wr_cyc = 0, overlap = 0;
    always @(negedge clk) begin
        if (sram_read_pulse) rd_cyc <= rd_cyc + 1;
        if (sram_write_pulse) wr_cyc <= wr_cyc + 1;
        if (sram_read_pulse && sram_write_pulse) overlap <= overlap + 1;
    end

    // Reference model: plain byte-addressed memory.
    logic [7:0] ref_mem [512];

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [8:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
        int          n, ea, cyc, rd0, wr0;
        bit          illegal, misal, exp_err, got;
        logic [31:0] exp_rd, exp_din;
        logic [3:0]  exp_bs;
        logic [63:0] v;

        n       = 1 << size[1:0];
        illegal = (size == 3'b011) || (size >= 3'b110) || (size[2] && we);
        misal   = !illegal && ((int'(addr) % n) != 0);
        exp_err = illegal;
`ifdef SRAM_CTRL_MISALIGN_TRAP_EN
        exp_err = exp_err || misal;
`endif
        exp_rd  = '0;
        exp_din = '0;
        exp_bs  = '0;
        if (!exp_err) begin
            ea      = int'(addr) - (int'(addr) % n);
            exp_bs  = 4'(((1 << n) - 1) << (ea % 4));
            exp_din = wdata << (8 * (ea % 4));
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[ea + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_mem[ea + i]) << (8 * i));
                if (!size[2] && n < 4 && v[8*n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                exp_rd = v[31:0];
            end
        end

        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !exp_err) begin
                check("setup_addr_sel", 32'(sram_addr_sel), 32'(addr[8:2]));
                check("setup_byte_sel", 32'(sram_byte_sel), 32'(exp_bs));
                if (we) check("setup_datain", sram_datain, exp_din);
                check("setup_no_pulse", 32'({sram_read_pulse, sram_write_pulse}), 32'd0);
            end
            if (rsp_valid) got = 1'b1;
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("rsp_latency", 32'(cyc), exp_err ? 32'd1 : 32'(PULSE_CYCLES + 3));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rd);
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("read_pulse_cycles", 32'(rd_cyc - rd0), (!exp_err && !we) ? 32'(PULSE_CYCLES) : 32'd0);
        check("write_pulse_cycles", 32'(wr_cyc - wr0), (!exp_err && we) ? 32'(PULSE_CYCLES) : 32'd0);
        check("idle_sel_zero", 32'(sram_addr_sel) | 32'(sram_byte_sel), 32'd0);
        check("idle_datain_zero", sram_datain, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < SRAM_WORDS; i++) sram_mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp", 32'({rsp_valid, rsp_err, sram_read_pulse, sram_write_pulse}), 32'd0);
        check("reset_sram_sel", 32'(sram_addr_sel) | 32'(sram_byte_sel), 32'd0);
        check("reset_datain_rdata", sram_datain | rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Directed cases
        do_req(1'b1, 9'h010, SIZE_W,  32'hDEADBEEF);
        do_req(1'b0, 9'h010, SIZE_W,  32'h0);
        do_req(1'b1, 9'h013, SIZE_B,  32'h00000080);
        do_req(1'b0, 9'h013, SIZE_B,  32'h0);
        do_req(1'b0, 9'h013, SIZE_BU, 32'h0);
        do_req(1'b1, 9'h022, SIZE_H,  32'h00001234);
        do_req(1'b0, 9'h022, SIZE_H,  32'h0);
        do_req(1'b0, 9'h022, SIZE_HU, 32'h0);
        do_req(1'b0, 9'h010, 3'b011,  32'h0);
        do_req(1'b1, 9'h010, 3'b110,  32'h12345678);
        do_req(1'b0, 9'h010, 3'b111,  32'h0);
        do_req(1'b1, 9'h010, SIZE_BU, 32'h55);
        do_req(1'b1, 9'h014, SIZE_HU, 32'h55);
        do_req(1'b0, 9'h011, SIZE_W,  32'h0);
        do_req(1'b1, 9'h031, SIZE_H,  32'hFFFF8001);
        do_req(1'b0, 9'h030, SIZE_W,  32'h0);
        do_req(1'b1, 9'h1FC, SIZE_W,  32'hA5A5_5A5A);
        do_req(1'b0, 9'h1FF, SIZE_B,  32'h0);

        // Reset asserted in the middle of a read pulse
        @(negedge clk);
        check("ready_before_abort", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'h010;
        req_size  = SIZE_W;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_pulse", 32'(sram_read_pulse), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_pulse_drop", 32'({sram_read_pulse, sram_write_pulse}), 32'd0);
        check("abort_ready_low", 32'(req_ready), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        do_req(1'b0, 9'h010, SIZE_W, 32'h0);
        do_req(1'b1, 9'h044, SIZE_W, 32'hCAFEF00D);
        do_req(1'b0, 9'h046, SIZE_H, 32'h0);

        // Random traffic over the whole address space and all size codes
        for (int k = 0; k < 60; k++) begin
            do_req(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                   3'($urandom_range(0, 7)), $urandom);
        end

        check("pulse_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
